// File: rtl/ej32_pkg.sv
// Shared types and defaults for the ej32 RAM dump block.
package ej32_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} dump_st_t;

    localparam int DUMP_FIFO_D = 4;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/ej32_dump_fifo.sv
// Synchronous first-word-fall-through byte FIFO: dout shows the head whenever empty=0.
module ej32_dump_fifo
    import ej32_pkg::*;
#(
    parameter int DEPTH = DUMP_FIFO_D
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; clearing pointers and count already empties the FIFO.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ej32_ram_dump.sv
// Streams RAM bytes a0..a0+len-1 (wrapping) from the 8-bit memory bus onto a valid/ready byte stream.
// Define EJ32_DUMP_CSUM_EN to append a byte making the stream sum to zero mod 256.
module ej32_ram_dump
    import ej32_pkg::*;
#(
    parameter int ASZ    = 17,
    parameter int LEN_SZ = 17,
    parameter int RD_LAT = 1,
    parameter int FIFO_D = DUMP_FIFO_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ASZ-1:0]    a0,
    input  logic [LEN_SZ-1:0] len,
    output logic [ASZ-1:0]    ma,
    output logic              mre,
    input  logic [7:0]        md,
    output logic [7:0]        tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              busy,
    output logic              done
);
    localparam int CW  = $clog2(FIFO_D) + 1;
    localparam int CW1 = CW + 1;

    dump_st_t          state, state_nx;
    logic [ASZ-1:0]    addr;
    logic [LEN_SZ-1:0] rem;
    logic [RD_LAT-1:0] infl;
    logic [CW-1:0]     infl_cnt;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty, fifo_full;
    byte_t             fifo_head;
    logic              accept, zero_start, issue, push, pop, finish;

    assign accept     = (state == IDLE) && start && (len != '0);
    assign zero_start = (state == IDLE) && start && (len == '0);
    assign push       = infl[RD_LAT-1];
    assign pop        = !fifo_empty && tready;
    // A read is only issued if its byte is guaranteed a FIFO slot when it returns.
    assign issue      = (state == RUN) && (rem != '0) && !fifo_full &&
                        (CW1'(fifo_cnt) + CW1'(infl_cnt) < CW1'(FIFO_D));

    ej32_dump_fifo #(.DEPTH(FIFO_D)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (md),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (issue && rem == LEN_SZ'(1)) state_nx = DRAIN;
            DRAIN:   if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mre  = issue;
        ma   = addr;
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            rem      <= '0;
            infl     <= '0;
            infl_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done    <= finish || zero_start;
            infl[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) infl[i] <= infl[i-1];
            infl_cnt <= infl_cnt + CW'(issue) - CW'(push);
            if (accept) begin
                addr <= a0;
                rem  <= len;
            end else if (issue) begin
                addr <= addr + ASZ'(1);
                rem  <= rem - LEN_SZ'(1);
            end
        end
    end

`ifdef EJ32_DUMP_CSUM_EN
    byte_t sum;
    logic  csum_phase;

    // Once every data byte has left, the stream presents the checksum byte.
    assign csum_phase = (state == DRAIN) && (infl_cnt == '0) && fifo_empty;
    assign finish     = csum_phase && tready;

    always_comb begin
        tvalid = !fifo_empty || csum_phase;
        if (csum_phase)      tdata = 8'd0 - sum;
        else if (fifo_empty) tdata = 8'd0;
        else                 tdata = fifo_head;
    end

    always_ff @(posedge clk) begin
        if (rst || accept) sum <= '0;
        else if (pop)      sum <= sum + fifo_head;
    end
`else
    assign finish = (state == DRAIN) && (infl_cnt == '0) &&
                    (fifo_empty || (fifo_cnt == CW'(1) && pop));

    always_comb begin
        tvalid = !fifo_empty;
        tdata  = fifo_empty ? 8'd0 : fifo_head;
    end
`endif

endmodule

// File: tb/tb_ej32_ram_dump.sv
// Directed self-checking bench for ej32_ram_dump with a behavioural 1-cycle-latency RAM.
module tb_ej32_ram_dump;

`ifdef EJ32_DUMP_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, tready, mre, tvalid, busy, done;
    logic [16:0] a0, len, ma;
    logic [7:0]  md, tdata;

    always #5 clk = ~clk;

    ej32_ram_dump dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a0     (a0),
        .len    (len),
        .ma     (ma),
        .mre    (mre),
        .md     (md),
        .tdata  (tdata),
        .tvalid (tvalid),
        .tready (tready),
        .busy   (busy),
        .done   (done)
    );

    logic [7:0] ram [0:131071];
    always @(posedge clk) if (mre) md <= ram[ma];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    int          cyc = 0;
    int          issued, txn, first_tv, first_tx, last_tx, done_cnt, done_cyc, hold_err, max_out;
    int          coinc_err = 0;
    logic        busy_seen, hold_pend;
    logic [7:0]  hold_data;
    logic [7:0]  got_q [$];
    logic [16:0] ma_q [$];
    logic [7:0]  exp_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && (!tvalid || tdata !== hold_data)) hold_err++;
            hold_pend = tvalid && !tready;
            hold_data = tdata;
            if (busy) busy_seen = 1'b1;
            if (mre) begin
                issued++;
                ma_q.push_back(ma);
            end
            if (issued - txn > max_out) max_out = issued - txn;
            if (tvalid && first_tv < 0) first_tv = cyc;
            if (tvalid && tready) begin
                if (txn == 0) first_tx = cyc;
                last_tx = cyc;
                txn++;
                got_q.push_back(tdata);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (tvalid) coinc_err++;
            end
        end
    end

    task automatic clear_mon();
        issued = 0; txn = 0; first_tv = -1; first_tx = -1; last_tx = -1;
        done_cnt = 0; done_cyc = -1; hold_err = 0; max_out = 0;
        busy_seen = 1'b0; hold_pend = 1'b0;
        got_q.delete();
        ma_q.delete();
    endtask

    task automatic add_csum();
`ifdef EJ32_DUMP_CSUM_EN
        logic [7:0] s = 8'd0;
        foreach (exp_q[i]) s = s + exp_q[i];
        exp_q.push_back(8'd0 - s);
`endif
    endtask

    task automatic compare_bytes(input string pfx);
        check({pfx, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) check($sformatf("%s_b%0d", pfx, i), got_q[i], exp_q[i]);
    endtask

    // 1,0,0,1,... with a 20-cycle stall window.
    function automatic logic rdy(input int mode, input int c);
        if (mode != 1) return 1'b1;
        if (c >= 5 && c < 25) return 1'b0;
        return (c % 3 == 0);
    endfunction

    int acc_cyc;

    // acc_cyc is the cycle following the edge that accepted start.
    task automatic run_job(input logic [16:0] a, input logic [16:0] n, input int mode);
        clear_mon();
        a0 = a; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc_cyc = cyc;
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            tready = rdy(mode, c);
            if (mode == 2) begin
                start = (c == 3);
                len   = 17'd3;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        tready = 1'b1;
        check("done_seen", done_cnt != 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("busy_end", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a0 = '0; len = '0; tready = 1'b1;
        for (int i = 0; i < 8; i++) ram[17'h100 + i] = 8'(i + 1);
        ram[17'h1FFFE] = 8'hAA; ram[17'h1FFFF] = 8'hBB; ram[17'h0] = 8'hCC; ram[17'h1] = 8'hDD;
        ram[17'h200] = 8'h5A; ram[17'h201] = 8'hA5;
        ram[17'h300] = 8'h10; ram[17'h301] = 8'h20; ram[17'h302] = 8'h30;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ma", ma, 17'h0);
        check("rst_ctl", {mre, tvalid, busy, done}, 4'b0000);
        check("rst_tdata", tdata, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic dump, tready always high.
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        add_csum();
        run_job(17'h100, 17'd8, 0);
        compare_bytes("basic");
        check("basic_lat", first_tv - acc_cyc, 2);
        check("basic_burst", last_tx - first_tx, 7 + CS);
        check("basic_done_lat", done_cyc - last_tx, 1);
        check("basic_mre", issued, 8);

        // Backpressure.
        run_job(17'h100, 17'd8, 1);
        compare_bytes("bp");
        check("bp_hold", hold_err, 0);
        check("bp_outstanding", max_out <= 4, 1'b1);
        check("bp_mre", issued, 8);

        // Address wrap.
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        add_csum();
        run_job(17'h1FFFE, 17'd4, 0);
        compare_bytes("wrap");
        check("wrap_nma", ma_q.size(), 4);
        if (ma_q.size() == 4) begin
            check("wrap_ma0", ma_q[0], 17'h1FFFE);
            check("wrap_ma1", ma_q[1], 17'h1FFFF);
            check("wrap_ma2", ma_q[2], 17'h00000);
            check("wrap_ma3", ma_q[3], 17'h00001);
        end

        // Zero length: done in the cycle after the accepting edge, no reads, no busy.
        exp_q.delete();
        run_job(17'h100, 17'd0, 0);
        check("zl_done_lat", done_cyc - acc_cyc, 0);
        check("zl_mre", issued, 0);
        check("zl_busy", busy_seen, 1'b0);
        check("zl_bytes", got_q.size(), 0);

        // Start while busy is ignored.
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        add_csum();
        run_job(17'h100, 17'd8, 2);
        compare_bytes("busy_start");
        check("busy_start_mre", issued, 8);

        // Reset after three bytes have transferred.
        clear_mon();
        a0 = 17'h100; len = 17'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && txn < 3; c++) begin
            @(posedge clk); #1;
        end
        check("rm_three", txn, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rm_tvalid", tvalid, 1'b0);
        check("rm_busy", busy, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("rm_nodone", done_cnt, 0);
        exp_q = '{8'h5A, 8'hA5};
        add_csum();
        run_job(17'h200, 17'd2, 0);
        compare_bytes("rm_after");

        // Three bytes; with the checksum option the stream ends in A0.
        exp_q = '{8'h10, 8'h20, 8'h30};
        add_csum();
        run_job(17'h300, 17'd3, 0);
        compare_bytes("csum");
        if (CS == 1) check("csum_byte", got_q[got_q.size() - 1], 8'hA0);

        check("done_vs_tvalid", coinc_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
